// File: rtl/alu_iter.sv
// Multi-cycle integer ALU: single-cycle logic/arith/compare, one-bit-per-cycle shifts
// with a start/busy/done handshake and a registered result.
module alu_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SRA = 4'b0111,
    OP_EQ  = 4'b1000,
    OP_GE  = 4'b1001,
    OP_SLT = 4'b1100
  } op_t;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  typedef enum logic [1:0] {
    SK_LL,
    SK_RL,
    SK_RA
  } shift_t;

  state_t           state;
  shift_t           kind;
  shift_t           kind_new;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   count;

  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic [WIDTH-1:0] quick_res;
  logic [WIDTH-1:0] shifted;

  assign shamt = SrcB[SHW-1:0];

  // Result of every op that finishes in the accept cycle; a zero-length shift is just SrcA.
  always_comb begin
    quick_res = '0;
    is_shift  = 1'b0;
    kind_new  = SK_LL;
    case (op_t'(Operation))
      OP_AND: quick_res = SrcA & SrcB;
      OP_OR:  quick_res = SrcA | SrcB;
      OP_XOR: quick_res = SrcA ^ SrcB;
      OP_ADD: quick_res = SrcA + SrcB;
      OP_SUB: quick_res = SrcA - SrcB;
      OP_SLT: quick_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_EQ:  quick_res = {{(WIDTH-1){1'b0}}, (SrcA == SrcB)};
      OP_GE:  quick_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) >= $signed(SrcB))};
      OP_SLL: begin
        quick_res = SrcA;
        is_shift  = 1'b1;
        kind_new  = SK_LL;
      end
      OP_SRL: begin
        quick_res = SrcA;
        is_shift  = 1'b1;
        kind_new  = SK_RL;
      end
      OP_SRA: begin
        quick_res = SrcA;
        is_shift  = 1'b1;
        kind_new  = SK_RA;
      end
      default: quick_res = '0;
    endcase
  end

  always_comb begin
    shifted = acc;
    case (kind)
      SK_LL:   shifted = {acc[WIDTH-2:0], 1'b0};
      SK_RL:   shifted = {1'b0, acc[WIDTH-1:1]};
      SK_RA:   shifted = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: shifted = acc;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      kind      <= SK_LL;
      acc       <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ALUResult <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_shift && (shamt != '0)) begin
              acc   <= SrcA;
              count <= shamt;
              kind  <= kind_new;
              busy  <= 1'b1;
              state <= SHIFT;
            end else begin
              ALUResult <= quick_res;
              done      <= 1'b1;
            end
          end
        end
        SHIFT: begin
          acc   <= shifted;
          count <= count - 1'b1;
          if (count == SHW'(1)) begin
            ALUResult <= shifted;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed and randomized bench for alu_iter against an arithmetic reference model.
module tb_alu_iter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic        done;
  logic [31:0] ALUResult;

  int unsigned vectors;
  int unsigned errors;
  logic [31:0] prev;

  alu_iter #(.WIDTH(32), .SHW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .busy      (busy),
    .done      (done),
    .ALUResult (ALUResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0011: return a ^ b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0100: return a << sh;
      4'b0101: return a >> sh;
      4'b0111: return $unsigned($signed(a) >>> sh);
      4'b1100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return (a == b) ? 32'd1 : 32'd0;
      4'b1001: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int unsigned shift_len(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'b0100 || op == 4'b0101 || op == 4'b0111) return b % 32;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction from an idle block, checking every cycle of its latency.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp;
    int unsigned n;
    exp = ref_alu(op, a, b);
    n   = shift_len(op, b);
    @(negedge clk);
    start = 1'b1; Operation = op; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) begin
      chk({tag, ".done"}, 32'(done), 32'd1);
      chk({tag, ".busy"}, 32'(busy), 32'd0);
      chk({tag, ".res"}, ALUResult, exp);
    end else begin
      chk({tag, ".busy0"}, 32'(busy), 32'd1);
      chk({tag, ".done0"}, 32'(done), 32'd0);
      for (int unsigned k = 1; k <= n; k++) begin
        SrcA = $urandom; Operation = 4'(($urandom));
        @(posedge clk); #1;
        if (k < n) begin
          if (busy !== 1'b1 || done !== 1'b0 || ALUResult !== prev)
            chk({tag, ".mid"}, {busy, done, 30'd0} ^ (ALUResult ^ prev), {2'b10, 30'd0});
        end
      end
      chk({tag, ".done"}, 32'(done), 32'd1);
      chk({tag, ".busy"}, 32'(busy), 32'd0);
      chk({tag, ".res"}, ALUResult, exp);
    end
    prev = exp;
    @(posedge clk); #1;
    chk({tag, ".done_off"}, 32'(done), 32'd0);
  endtask

  initial begin
    int unsigned dones;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    vectors = 0; errors = 0; prev = '0;
    reset = 1'b0; start = 1'b0; Operation = '0; SrcA = '0; SrcB = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.res", ALUResult, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("add_wrap", 4'b0010, 32'h7FFF_FFFF, 32'd1);
    run_op("sub", 4'b0110, 32'd5, 32'd7);
    run_op("xor", 4'b0011, 32'hF0F0_F0F0, 32'hFFFF_0000);
    run_op("undef", 4'b1111, 32'hDEAD_BEEF, 32'h1234_5678);
    run_op("slt", 4'b1100, 32'hFFFF_FFFF, 32'd1);
    run_op("ge", 4'b1001, 32'hFFFF_FFFF, 32'd1);
    run_op("eq", 4'b1000, 32'h1234, 32'h1234);
    run_op("sra31", 4'b0111, 32'h8000_0000, 32'd31);
    run_op("srl31", 4'b0101, 32'h8000_0000, 32'd31);
    run_op("sll0", 4'b0100, 32'd1, 32'd0);

    // Reset in the middle of an SRA by 20 must abandon it silently.
    @(negedge clk);
    start = 1'b1; Operation = 4'b0111; SrcA = 32'h9000_0001; SrcB = 32'd20;
    @(posedge clk); #1;
    start = 1'b0;
    chk("midrst.busy_pre", 32'(busy), 32'd1);
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.res", ALUResult, 32'd0);
    prev = '0;
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("midrst.no_done", dones, 32'd0);
    chk("midrst.res_hold", ALUResult, 32'd0);

    // Starts and operand changes while busy must be ignored.
    @(negedge clk);
    start = 1'b1; Operation = 4'b0100; SrcA = 32'd3; SrcB = 32'd4;
    @(posedge clk); #1;
    dones = 0;
    for (int unsigned k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = (k != 1); Operation = 4'b0010; SrcA = $urandom; SrcB = $urandom;
      @(posedge clk); #1;
      if (done) dones++;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("busy.dones", dones, 32'd1);
    chk("busy.res", ALUResult, 32'h30);
    prev = 32'h30;

    // Held start gives one result per cycle.
    @(negedge clk);
    start = 1'b1; Operation = 4'b0010;
    for (int unsigned k = 1; k <= 3; k++) begin
      SrcA = k; SrcB = k;
      @(posedge clk); #1;
      chk("thru.done", 32'(done), 32'd1);
      chk("thru.res", ALUResult, 2 * k);
      @(negedge clk);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("thru.done_off", 32'(done), 32'd0);
    prev = 32'd6;

    for (int unsigned i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 3) == 0) b = {27'd0, 5'($urandom_range(0, 2))};
      run_op("rand", op, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
